// File: rtl/automata_report_collector.sv
`default_nettype none
// ============================================================================
// Module   : automata_report_collector
// Brief    : Aligns symbol offsets to automaton reports, buffers report
//            records in a FWFT FIFO and drains them over valid/ready.
// Revision : 1.0 - initial release
// ============================================================================
module automata_report_collector #(
    parameter int N_REPORTS      = 1,
    parameter int OFFSET_W       = 32,
    parameter int DEPTH          = 16,
    parameter int REPORT_LATENCY = 1
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     run,
    input  logic                     last,
    input  logic [N_REPORTS-1:0]     report_in,
    output logic                     rec_valid,
    input  logic                     rec_ready,
    output logic [OFFSET_W-1:0]      rec_offset,
    output logic [N_REPORTS-1:0]     rec_reports,
    output logic [$clog2(DEPTH):0]   fifo_count,
    output logic                     overflow,
    output logic [15:0]              drop_count,
    output logic                     done
);

    localparam int                  c_addr_w   = $clog2(DEPTH);
    localparam logic [c_addr_w:0]   c_full     = (c_addr_w + 1)'(DEPTH);
    localparam logic [c_addr_w:0]   c_cnt_one  = (c_addr_w + 1)'(1);
    localparam logic [c_addr_w-1:0] c_ptr_one  = c_addr_w'(1);
    localparam logic [OFFSET_W-1:0] c_off_one  = OFFSET_W'(1);

    typedef enum logic [1:0] {
        ST_STREAM = 2'd0,
        ST_DRAIN  = 2'd1,
        ST_DONE   = 2'd2
    } state_t;

    state_t                r_state;
    logic                  r_done;
    logic [OFFSET_W-1:0]   r_sym_cnt;

    logic [REPORT_LATENCY-1:0] r_dl_run;
    logic [OFFSET_W-1:0]       r_dl_off [REPORT_LATENCY];

    logic [OFFSET_W-1:0]   r_mem_off [DEPTH];
    logic [N_REPORTS-1:0]  r_mem_rep [DEPTH];
    logic [c_addr_w-1:0]   r_wr_ptr;
    logic [c_addr_w-1:0]   r_rd_ptr;
    logic [c_addr_w:0]     r_count;
    logic                  r_overflow;
    logic [15:0]           r_drop_count;

    logic                  w_g_run;
    logic                  w_d_run;
    logic [OFFSET_W-1:0]   w_d_off;
    logic                  w_dl_busy;
    logic                  w_empty;
    logic                  w_full;
    logic                  w_capture;
    logic                  w_pop;
    logic                  w_push;
    logic                  w_drop;

    assign w_g_run   = run && (r_state == ST_STREAM);
    assign w_d_run   = r_dl_run[REPORT_LATENCY-1];
    assign w_d_off   = r_dl_off[REPORT_LATENCY-1];
    assign w_dl_busy = |r_dl_run;

    assign w_empty   = (r_count == '0);
    assign w_full    = (r_count == c_full);
    assign w_capture = w_d_run && (|report_in);
    assign w_pop     = !w_empty && rec_ready;
    // A full FIFO still accepts the new record when the head leaves this cycle.
    assign w_push    = w_capture && (!w_full || w_pop);
    assign w_drop    = w_capture && w_full && !w_pop;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= ST_STREAM;
            r_done    <= 1'b0;
            r_sym_cnt <= '0;
        end else begin
            case (r_state)
                ST_STREAM: begin
                    if (w_g_run) begin
                        r_sym_cnt <= r_sym_cnt + c_off_one;
                        if (last) begin
                            r_state <= ST_DRAIN;
                        end
                    end
                end
                ST_DRAIN: begin
                    if (!w_dl_busy && w_empty) begin
                        r_state <= ST_DONE;
                        r_done  <= 1'b1;
                    end
                end
                ST_DONE: begin
                    r_done <= 1'b1;
                end
                default: begin
                    r_state <= ST_STREAM;
                    r_done  <= 1'b0;
                end
            endcase
        end
    end

    // Each stage carries the run qualifier and the offset of the symbol whose
    // report arrives when it reaches the end of the line.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_dl_run <= '0;
        end else begin
            r_dl_run[0] <= w_g_run;
            for (int i = 1; i < REPORT_LATENCY; i++) begin
                r_dl_run[i] <= r_dl_run[i-1];
            end
        end
    end

    always_ff @(posedge clk) begin
        r_dl_off[0] <= r_sym_cnt;
        for (int i = 1; i < REPORT_LATENCY; i++) begin
            r_dl_off[i] <= r_dl_off[i-1];
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem_off[r_wr_ptr] <= w_d_off;
            r_mem_rep[r_wr_ptr] <= report_in;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + c_ptr_one;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + c_ptr_one;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + c_cnt_one;
                2'b01:   r_count <= r_count - c_cnt_one;
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_overflow   <= 1'b0;
            r_drop_count <= '0;
        end else if (w_drop) begin
            r_overflow <= 1'b1;
            if (r_drop_count != 16'hFFFF) begin
                r_drop_count <= r_drop_count + 16'd1;
            end
        end
    end

    assign rec_valid   = !w_empty;
    assign rec_offset  = r_mem_off[r_rd_ptr];
    assign rec_reports = r_mem_rep[r_rd_ptr];
    assign fifo_count  = r_count;
    assign overflow    = r_overflow;
    assign drop_count  = r_drop_count;
    assign done        = r_done;

endmodule
`default_nettype wire

// File: tb/tb_automata_report_collector.sv
`default_nettype none
// ============================================================================
// Module   : tb_automata_report_collector
// Brief    : Randomized and directed scoreboard bench for the report collector.
// Revision : 1.0 - initial release
// ============================================================================
module tb_automata_report_collector;

    localparam int NR    = 3;
    localparam int OW    = 4;
    localparam int DEPTH = 16;
    localparam int LAT   = 1;

    typedef struct packed {
        logic [OW-1:0] off;
        logic [NR-1:0] rep;
    } rec_t;

    logic                   clk;
    logic                   reset;
    logic                   run;
    logic                   last;
    logic [NR-1:0]          report_in;
    logic                   rec_valid;
    logic                   rec_ready;
    logic [OW-1:0]          rec_offset;
    logic [NR-1:0]          rec_reports;
    logic [$clog2(DEPTH):0] fifo_count;
    logic                   overflow;
    logic [15:0]            drop_count;
    logic                   done;

    automata_report_collector #(
        .N_REPORTS      (NR),
        .OFFSET_W       (OW),
        .DEPTH          (DEPTH),
        .REPORT_LATENCY (LAT)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .run         (run),
        .last        (last),
        .report_in   (report_in),
        .rec_valid   (rec_valid),
        .rec_ready   (rec_ready),
        .rec_offset  (rec_offset),
        .rec_reports (rec_reports),
        .fifo_count  (fifo_count),
        .overflow    (overflow),
        .drop_count  (drop_count),
        .done        (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int   n_cmp = 0;
    int   n_bad = 0;
    bit   chk_en = 0;
    rec_t sb[$];

    // Reference model: symbols awaiting their report, occupancy, stream phase.
    int   m_phase;      // 0 streaming, 1 draining, 2 finished
    int   m_sym;
    bit   m_pend;
    int   m_pend_off;
    int   m_cnt;
    bit   m_ovf;
    int   m_drops;

    int   e_cnt;
    bit   e_valid;
    bit   e_ovf;
    int   e_drops;
    bit   e_done;

    task automatic check(input string nm, input longint act, input longint exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic model(input bit rs, input bit ru, input bit la,
                         input logic [NR-1:0] rp, input bit rd);
        bit   pop;
        bit   cap;
        bit   finish;
        bit   consume;
        rec_t r;
        if (rs) begin
            m_phase = 0; m_sym = 0; m_pend = 0; m_pend_off = 0;
            m_cnt = 0; m_ovf = 0; m_drops = 0;
            sb.delete();
        end else begin
            pop     = (m_cnt > 0) && rd;
            cap     = m_pend && (rp != '0);
            finish  = (m_phase == 1) && !m_pend && (m_cnt == 0);
            consume = ru && (m_phase == 0);
            if (cap) begin
                if (m_cnt < DEPTH || pop) begin
                    r.off = OW'(m_pend_off);
                    r.rep = rp;
                    sb.push_back(r);
                    m_cnt++;
                end else begin
                    m_ovf = 1;
                    if (m_drops < 65535) m_drops++;
                end
            end
            if (pop) m_cnt--;
            if (consume && la) m_phase = 1;
            else if (finish) m_phase = 2;
            m_pend     = consume;
            m_pend_off = m_sym;
            if (consume) m_sym = (m_sym + 1) % (1 << OW);
        end
        e_cnt   = m_cnt;
        e_valid = (m_cnt > 0);
        e_ovf   = m_ovf;
        e_drops = m_drops;
        e_done  = (m_phase == 2);
    endtask

    task automatic step(input bit rs, input bit ru, input bit la,
                        input logic [NR-1:0] rp, input bit rd);
        @(negedge clk);
        chk_en    = 1;
        reset     = rs;
        run       = ru;
        last      = la;
        report_in = rp;
        rec_ready = rs ? 1'b0 : rd;
        model(rs, ru, la, rp, rs ? 1'b0 : rd);
    endtask

    // Monitor: a handshake at an edge pops the head seen before that edge.
    initial begin
        bit            p_valid;
        logic [OW-1:0] p_off;
        logic [NR-1:0] p_rep;
        rec_t          exp;
        p_valid = 0;
        p_off   = '0;
        p_rep   = '0;
        forever begin
            @(posedge clk);
            #1;
            if (chk_en) begin
                if (p_valid && rec_ready) begin
                    if (sb.size() == 0) begin
                        check("unexpected_record", 1, 0);
                    end else begin
                        exp = sb.pop_front();
                        check("rec_offset", p_off, exp.off);
                        check("rec_reports", p_rep, exp.rep);
                    end
                end
                check("rec_valid", rec_valid, e_valid);
                check("fifo_count", fifo_count, e_cnt);
                check("overflow", overflow, e_ovf);
                check("drop_count", drop_count, e_drops);
                check("done", done, e_done);
            end
            p_valid = rec_valid;
            p_off   = rec_offset;
            p_rep   = rec_reports;
        end
    end

    initial begin
        bit            r;
        bit            l;
        bit            rd;
        bit            rs;
        logic [NR-1:0] rp;
        int            waited;

        reset = 1; run = 0; last = 0; report_in = '0; rec_ready = 0;

        // Reset with active-looking inputs.
        step(1, 1, 0, 3'b001, 0);
        step(1, 1, 0, 3'b001, 0);
        step(0, 0, 0, 3'b000, 0);
        check("rst_valid", rec_valid, 0);
        check("rst_count", fifo_count, 0);
        check("rst_done", done, 0);

        // Single report on symbol 3.
        step(1, 0, 0, 0, 1);
        for (int k = 0; k < 7; k++) step(0, k < 6, 0, (k == 4) ? 3'b001 : 3'b000, 1);
        for (int k = 0; k < 3; k++) step(0, 0, 0, 0, 1);

        // Backpressure and overflow: 18 reporting symbols into 16 slots.
        step(1, 0, 0, 0, 0);
        for (int k = 0; k < 19; k++) step(0, k < 18, 0, (k >= 1) ? 3'b001 : 3'b000, 0);
        step(0, 0, 0, 0, 0);
        check("ovf_count", fifo_count, 16);
        check("ovf_flag", overflow, 1);
        check("ovf_drops", drop_count, 2);

        // Full FIFO with simultaneous pop: report for symbol 20 is kept.
        for (int k = 0; k < 3; k++) step(0, 1, 0, 0, 0);
        step(0, 0, 0, 3'b001, 1);
        step(0, 0, 0, 0, 0);
        check("fullpop_count", fifo_count, 16);
        check("fullpop_drops", drop_count, 2);
        for (int k = 0; k < 20; k++) step(0, 0, 0, 0, 1);
        check("drained_valid", rec_valid, 0);

        // End of stream: last on symbol 9, run kept high afterwards.
        step(1, 0, 0, 0, 1);
        for (int k = 0; k < 10; k++)
            step(0, 1, k == 9, (k >= 1) ? NR'($urandom_range(0, 7)) : 3'b000, 1);
        step(0, 1, 0, 3'b101, 1);
        waited = 0;
        while (!done && waited < 40) begin
            step(0, 1, $urandom_range(0, 1), NR'($urandom_range(0, 7)), 1);
            waited++;
        end
        check("eos_done", done, 1);
        for (int k = 0; k < 5; k++) step(0, 1, 1, 3'b111, 1);

        // Offset wrap, then reset with records buffered.
        step(1, 0, 0, 0, 1);
        for (int k = 0; k < 19; k++) step(0, k < 18, 0, (k == 18) ? 3'b010 : 3'b000, 1);
        for (int k = 0; k < 3; k++) step(0, 0, 0, 0, 1);
        for (int k = 0; k < 6; k++) step(0, k < 5, 0, (k >= 1) ? 3'b011 : 3'b000, 0);
        step(0, 0, 0, 0, 0);
        check("buf_count", fifo_count, 5);
        step(1, 0, 0, 0, 0);
        step(0, 1, 0, 0, 1);
        check("midrst_valid", rec_valid, 0);
        check("midrst_count", fifo_count, 0);
        step(0, 0, 0, 3'b001, 1);
        for (int k = 0; k < 3; k++) step(0, 0, 0, 0, 1);

        // Randomized episodes; odd episodes apply heavy backpressure.
        for (int ep = 0; ep < 10; ep++) begin
            step(1, 0, 0, 0, 0);
            for (int c = 0; c < 500; c++) begin
                r  = ($urandom_range(0, 99) < 75);
                l  = ($urandom_range(0, 39) == 0);
                rp = $urandom_range(0, 1) ? NR'($urandom_range(1, 7)) : '0;
                rd = ($urandom_range(0, 99) < ((ep % 2) ? 30 : 80));
                rs = ($urandom_range(0, 399) == 0);
                step(rs, r, l, rp, rd);
            end
        end

        for (int k = 0; k < 40; k++) step(0, 0, 0, 0, 1);
        check("scoreboard_empty", sb.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
